// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core snooping bus controller arbitrating dcache/icache traffic onto one RAM port.
// Revision 1.0
`default_nettype none

module coherence_bus_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr0,
    input  logic [31:0] daddr1,
    input  logic [31:0] dstore0,
    input  logic [31:0] dstore1,
    input  logic [1:0]  cctrans,
    input  logic [1:0]  ccwrite,
    input  logic [1:0]  iREN,
    input  logic [31:0] iaddr0,
    input  logic [31:0] iaddr1,
    output logic [1:0]  dwait,
    output logic [31:0] dload0,
    output logic [31:0] dload1,
    output logic [1:0]  iwait,
    output logic [31:0] iload0,
    output logic [31:0] iload1,
    output logic [1:0]  ccwait,
    output logic [1:0]  ccinv,
    output logic [31:0] ccsnoopaddr0,
    output logic [31:0] ccsnoopaddr1,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WB0    = 4'd1,
        WB1    = 4'd2,
        SNOOP  = 4'd3,
        LOAD0  = 4'd4,
        LOAD1  = 4'd5,
        FWD0   = 4'd6,
        FWD1   = 4'd7,
        IFETCH = 4'd8
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;

    state_t      state, next_state;
    logic        req, next_req;
    logic        rsp;
    logic        dptr, next_dptr;
    logic        iptr, next_iptr;
    logic        access;
    logic        unused_cctrans;

    logic [31:0] daddr_v  [2];
    logic [31:0] dstore_v [2];
    logic [31:0] iaddr_v  [2];
    logic [31:0] dload_v  [2];
    logic [31:0] iload_v  [2];
    logic [31:0] snoop_v  [2];

    assign daddr_v[0]  = daddr0;
    assign daddr_v[1]  = daddr1;
    assign dstore_v[0] = dstore0;
    assign dstore_v[1] = dstore1;
    assign iaddr_v[0]  = iaddr0;
    assign iaddr_v[1]  = iaddr1;

    assign dload0       = dload_v[0];
    assign dload1       = dload_v[1];
    assign iload0       = iload_v[0];
    assign iload1       = iload_v[1];
    assign ccsnoopaddr0 = snoop_v[0];
    assign ccsnoopaddr1 = snoop_v[1];

    assign rsp    = ~req;
    assign access = (ramstate == RAM_ACCESS);

    // Transaction start is implied by dREN/dWEN; cctrans carries no extra decision here.
    assign unused_cctrans = ^cctrans;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req   <= 1'b0;
            dptr  <= 1'b0;
            iptr  <= 1'b0;
        end else begin
            state <= next_state;
            req   <= next_req;
            dptr  <= next_dptr;
            iptr  <= next_iptr;
        end
    end

    always_comb begin
        next_state = state;
        next_req   = req;
        next_dptr  = dptr;
        next_iptr  = iptr;
        dwait      = 2'b11;
        iwait      = 2'b11;
        ccwait     = 2'b00;
        ccinv      = 2'b00;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'h0;
        ramstore   = 32'h0;
        dload_v[0] = 32'h0;
        dload_v[1] = 32'h0;
        iload_v[0] = 32'h0;
        iload_v[1] = 32'h0;
        snoop_v[0] = 32'h0;
        snoop_v[1] = 32'h0;

        case (state)
            // Pointer names the core that wins the next tie; the winner hands priority to the other.
            IDLE: begin
                if (|dWEN) begin
                    next_req   = (dWEN == 2'b11) ? dptr : dWEN[1];
                    next_dptr  = ~next_req;
                    next_state = WB0;
                end else if (|dREN) begin
                    next_req   = (dREN == 2'b11) ? dptr : dREN[1];
                    next_dptr  = ~next_req;
                    next_state = SNOOP;
                end else if (|iREN) begin
                    next_req   = (iREN == 2'b11) ? iptr : iREN[1];
                    next_iptr  = ~next_req;
                    next_state = IFETCH;
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_v[req];
                ramstore = dstore_v[req];
                if (access) begin
                    dwait[req] = 1'b0;
                    next_state = (state == WB0) ? WB1 : IDLE;
                end
            end
            SNOOP: begin
                ccwait[rsp]  = 1'b1;
                snoop_v[rsp] = daddr_v[req];
                ccinv[rsp]   = ccwrite[req];
                next_state   = ccwrite[rsp] ? FWD0 : LOAD0;
            end
            LOAD0, LOAD1: begin
                ramREN       = 1'b1;
                ramaddr      = daddr_v[req];
                dload_v[req] = ramload;
                if (access) begin
                    dwait[req] = 1'b0;
                    next_state = (state == LOAD0) ? LOAD1 : IDLE;
                end
            end
            // Modified copy goes cache-to-cache and is written back to RAM in the same beat.
            FWD0, FWD1: begin
                ccwait[rsp]  = 1'b1;
                snoop_v[rsp] = daddr_v[req];
                ccinv[rsp]   = ccwrite[req];
                dload_v[req] = dstore_v[rsp];
                ramWEN       = 1'b1;
                ramaddr      = daddr_v[rsp];
                ramstore     = dstore_v[rsp];
                if (access) begin
                    dwait      = 2'b00;
                    next_state = (state == FWD0) ? FWD1 : IDLE;
                end
            end
            IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr_v[req];
                iload_v[req] = ramload;
                if (access) begin
                    iwait[req] = 1'b0;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
`default_nettype none

module tb_coherence_bus_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  dREN, dWEN, cctrans, ccwrite, iREN, ramstate;
    logic [31:0] daddr0, daddr1, dstore0, dstore1, iaddr0, iaddr1, ramload;
    logic [1:0]  dwait, iwait, ccwait, ccinv;
    logic [31:0] dload0, dload1, iload0, iload1, ccsnoopaddr0, ccsnoopaddr1;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;

    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN),
        .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
        .dwait(dwait), .dload0(dload0), .dload1(dload1),
        .iwait(iwait), .iload0(iload0), .iload1(iload1),
        .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one bus transaction at a time (writeback / block read / ifetch), counted in words.
    localparam int K_WB = 0, K_RD = 1, K_IF = 2;
    bit m_busy, m_r, m_snoop, m_fwd, m_words, m_dpri, m_ipri;
    bit n_busy, n_r, n_snoop, n_fwd, n_words, n_dpri, n_ipri;
    int m_kind, n_kind;

    logic [1:0]  e_dwait, e_iwait, e_ccwait, e_ccinv;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic [31:0] e_dl [2];
    logic [31:0] e_il [2];
    logic [31:0] e_sa [2];
    logic [31:0] da [2];
    logic [31:0] ds [2];
    logic [31:0] ia [2];
    bit          o, g, acc;

    always @(negedge CLK) begin
        da[0] = daddr0; da[1] = daddr1;
        ds[0] = dstore0; ds[1] = dstore1;
        ia[0] = iaddr0; ia[1] = iaddr1;
        e_dwait = 2'b11; e_iwait = 2'b11; e_ccwait = 2'b00; e_ccinv = 2'b00;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
        for (int i = 0; i < 2; i++) begin
            e_dl[i] = 32'h0; e_il[i] = 32'h0; e_sa[i] = 32'h0;
        end
        n_busy = m_busy; n_r = m_r; n_snoop = m_snoop; n_fwd = m_fwd;
        n_words = m_words; n_dpri = m_dpri; n_ipri = m_ipri; n_kind = m_kind;
        o   = ~m_r;
        acc = (ramstate == 2'b10);
        if (!nRST) begin
            n_busy = 0; n_r = 0; n_dpri = 0; n_ipri = 0;
        end else if (!m_busy) begin
            if (dWEN != 2'b00) begin
                g = (dWEN == 2'b11) ? m_dpri : dWEN[1];
                n_busy = 1; n_kind = K_WB; n_r = g; n_dpri = ~g; n_words = 0;
            end else if (dREN != 2'b00) begin
                g = (dREN == 2'b11) ? m_dpri : dREN[1];
                n_busy = 1; n_kind = K_RD; n_r = g; n_dpri = ~g; n_words = 0;
                n_snoop = 1; n_fwd = 0;
            end else if (iREN != 2'b00) begin
                g = (iREN == 2'b11) ? m_ipri : iREN[1];
                n_busy = 1; n_kind = K_IF; n_r = g; n_ipri = ~g;
            end
        end else if (m_kind == K_WB) begin
            e_wen = 1; e_addr = da[m_r]; e_store = ds[m_r];
            if (acc) begin
                e_dwait[m_r] = 1'b0;
                if (m_words) n_busy = 0; else n_words = 1;
            end
        end else if (m_kind == K_RD && m_snoop) begin
            e_ccwait[o] = 1'b1; e_sa[o] = da[m_r]; e_ccinv[o] = ccwrite[m_r];
            n_snoop = 0; n_fwd = ccwrite[o]; n_words = 0;
        end else if (m_kind == K_RD && !m_fwd) begin
            e_ren = 1; e_addr = da[m_r]; e_dl[m_r] = ramload;
            if (acc) begin
                e_dwait[m_r] = 1'b0;
                if (m_words) n_busy = 0; else n_words = 1;
            end
        end else if (m_kind == K_RD) begin
            e_ccwait[o] = 1'b1; e_sa[o] = da[m_r]; e_ccinv[o] = ccwrite[m_r];
            e_dl[m_r] = ds[o];
            e_wen = 1; e_addr = da[o]; e_store = ds[o];
            if (acc) begin
                e_dwait = 2'b00;
                if (m_words) n_busy = 0; else n_words = 1;
            end
        end else begin
            e_ren = 1; e_addr = ia[m_r]; e_il[m_r] = ramload;
            if (acc) begin
                e_iwait[m_r] = 1'b0;
                n_busy = 0;
            end
        end
        chk("dwait", {30'h0, dwait}, {30'h0, e_dwait});
        chk("iwait", {30'h0, iwait}, {30'h0, e_iwait});
        chk("ccwait", {30'h0, ccwait}, {30'h0, e_ccwait});
        chk("ccinv", {30'h0, ccinv}, {30'h0, e_ccinv});
        chk("ramREN", {31'h0, ramREN}, {31'h0, e_ren});
        chk("ramWEN", {31'h0, ramWEN}, {31'h0, e_wen});
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("dload0", dload0, e_dl[0]);
        chk("dload1", dload1, e_dl[1]);
        chk("iload0", iload0, e_il[0]);
        chk("iload1", iload1, e_il[1]);
        chk("ccsnoopaddr0", ccsnoopaddr0, e_sa[0]);
        chk("ccsnoopaddr1", ccsnoopaddr1, e_sa[1]);
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy <= 0; m_r <= 0; m_snoop <= 0; m_fwd <= 0; m_words <= 0;
            m_dpri <= 0; m_ipri <= 0; m_kind <= K_WB;
        end else begin
            m_busy <= n_busy; m_r <= n_r; m_snoop <= n_snoop; m_fwd <= n_fwd;
            m_words <= n_words; m_dpri <= n_dpri; m_ipri <= n_ipri; m_kind <= n_kind;
        end
    end

    task automatic idle_inputs();
        dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0; iREN = 0; ramstate = 2'b10;
        daddr0 = 0; daddr1 = 0; dstore0 = 0; dstore1 = 0; iaddr0 = 0; iaddr1 = 0;
        ramload = 32'h0BAD_F00D;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Uncontended block load by core 0
        dREN = 2'b01; cctrans = 2'b01; daddr0 = 32'h100;
        #2 chk("A idle dwait", {30'h0, dwait}, 32'h3);
        step(); #2 chk("A snoop ccwait", {30'h0, ccwait}, 32'h2);
        chk("A snoop addr1", ccsnoopaddr1, 32'h100);
        chk("A snoop ccinv", {30'h0, ccinv}, 32'h0);
        step(); #2 chk("A load0 ramREN", {31'h0, ramREN}, 32'h1);
        chk("A load0 ramaddr", ramaddr, 32'h100);
        chk("A load0 dwait", {30'h0, dwait}, 32'h2);
        step(); daddr0 = 32'h104; dREN = 0; cctrans = 0;
        #2 chk("A load1 dwait", {30'h0, dwait}, 32'h2);
        chk("A load1 ramaddr", ramaddr, 32'h104);
        step(); #2 chk("A back idle dwait", {30'h0, dwait}, 32'h3);
        chk("A back idle ramREN", {31'h0, ramREN}, 32'h0);

        // Read-exclusive by core 1 hitting modified copy in core 0, reset during FWD1
        step(); dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b11;
        daddr1 = 32'h200; daddr0 = 32'h208; dstore0 = 32'hDEADBEEF;
        #2 chk("B idle dwait", {30'h0, dwait}, 32'h3);
        step(); #2 chk("B snoop ccinv", {30'h0, ccinv}, 32'h1);
        chk("B snoop addr0", ccsnoopaddr0, 32'h200);
        step(); #2 chk("B fwd0 dload1", dload1, 32'hDEADBEEF);
        chk("B fwd0 ramWEN", {31'h0, ramWEN}, 32'h1);
        chk("B fwd0 ramaddr", ramaddr, 32'h208);
        chk("B fwd0 dwait", {30'h0, dwait}, 32'h0);
        chk("B fwd0 ccwait", {30'h0, ccwait}, 32'h1);
        step(); daddr0 = 32'h20C; dREN = 0; cctrans = 0;
        #2 chk("B fwd1 ramaddr", ramaddr, 32'h20C);
        chk("B fwd1 ccinv", {30'h0, ccinv}, 32'h1);
        nRST = 1'b0;
        #1 chk("B reset ramWEN", {31'h0, ramWEN}, 32'h0);
        chk("B reset ccwait", {30'h0, ccwait}, 32'h0);
        chk("B reset dwait", {30'h0, dwait}, 32'h3);
        chk("B reset iwait", {30'h0, iwait}, 32'h3);
        idle_inputs();
        step(); nRST = 1'b1;

        // Simultaneous writebacks: core 0, core 1, then core 0 again
        dWEN = 2'b11; daddr0 = 32'h300; daddr1 = 32'h400; dstore0 = 32'h11; dstore1 = 32'h22;
        #2 chk("C idle dwait", {30'h0, dwait}, 32'h3);
        step(); #2 chk("C wb0 ramaddr", ramaddr, 32'h300);
        chk("C wb0 ramstore", ramstore, 32'h11);
        chk("C wb0 dwait", {30'h0, dwait}, 32'h2);
        step(); daddr0 = 32'h304; dWEN = 2'b10;
        #2 chk("C wb1 ramaddr", ramaddr, 32'h304);
        step(); #2 chk("C idle2 ramWEN", {31'h0, ramWEN}, 32'h0);
        step(); #2 chk("C core1 ramaddr", ramaddr, 32'h400);
        chk("C core1 dwait", {30'h0, dwait}, 32'h1);
        step(); dWEN = 2'b11; daddr0 = 32'h500;
        #2 chk("C core1 wb1 dwait", {30'h0, dwait}, 32'h1);
        step();
        step(); #2 chk("C retie ramaddr", ramaddr, 32'h500);
        chk("C retie dwait", {30'h0, dwait}, 32'h2);
        step(); dWEN = 0;
        step();

        // icache request loses to a dcache request
        step(); iREN = 2'b01; iaddr0 = 32'h40; dREN = 2'b10; cctrans = 2'b10; ccwrite = 0;
        daddr1 = 32'h600;
        step(); #2 chk("D snoop ccwait", {30'h0, ccwait}, 32'h1);
        chk("D snoop iwait", {30'h0, iwait}, 32'h3);
        step(); #2 chk("D load0 ramaddr", ramaddr, 32'h600);
        step(); dREN = 0; cctrans = 0;
        #2 chk("D load1 dwait", {30'h0, dwait}, 32'h1);
        step(); #2 chk("D idle iwait", {30'h0, iwait}, 32'h3);
        step(); iREN = 0;
        #2 chk("D ifetch iwait", {30'h0, iwait}, 32'h2);
        chk("D ifetch ramaddr", ramaddr, 32'h40);
        step(); #2 chk("D after iwait", {30'h0, iwait}, 32'h3);

        // RAM busy during LOAD0
        step(); dREN = 2'b01; cctrans = 2'b01; daddr0 = 32'h700;
        step();
        step(); ramstate = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #2 chk("E busy dwait", {30'h0, dwait}, 32'h3);
            chk("E busy ramREN", {31'h0, ramREN}, 32'h1);
            step();
        end
        ramstate = 2'b10;
        #2 chk("E access dwait", {30'h0, dwait}, 32'h2);
        step(); dREN = 0; cctrans = 0;
        #2 chk("E load1 dwait", {30'h0, dwait}, 32'h2);
        step(); #2 chk("E idle dwait", {30'h0, dwait}, 32'h3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            dWEN    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            dREN    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            iREN    = 2'($urandom);
            cctrans = dREN;
            ccwrite = 2'($urandom);
            daddr0  = $urandom & 32'h0000_0FFC;
            daddr1  = $urandom & 32'h0000_0FFC;
            dstore0 = $urandom;
            dstore1 = $urandom;
            iaddr0  = $urandom & 32'h0000_0FFC;
            iaddr1  = $urandom & 32'h0000_0FFC;
            ramload = $urandom;
            case ($urandom_range(0, 9))
                0: ramstate = 2'b00;
                1: ramstate = 2'b01;
                2: ramstate = 2'b11;
                default: ramstate = 2'b10;
            endcase
            if (!nRST) nRST = 1'b1;
            else if ($urandom_range(0, 199) == 0) begin
                #1 nRST = 1'b0;
            end
        end
        nRST = 1'b1;
        idle_inputs();
        repeat (4) @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
